// File: rtl/bit_timer.sv
// ---------------------------------------------------------------------------
// bit_timer
//
// Bit-timing engine for the serial transmit/receive paths. The system clock
// is divided into bit periods by a runtime-loadable divisor. A runtime-
// selectable number of bits makes up one frame. An optional half-bit start
// offset lets a receiver align its sample point to the middle of each bit.
//
// Parameters
//   DIV_W        width of the cycles-per-bit divisor
//   CNT_W        width of the bit count and bit index
//   DEFAULT_DIV  divisor value after reset (50 MHz / 9600 baud)
//
// Ports
//   clock       in   system clock, rising-edge
//   reset       in   synchronous, active-low reset
//   start       in   begin a frame (accepted in IDLE or DONE only)
//   half_start  in   with an accepted start: shorten the first bit to half
//   abort       in   return to IDLE from any state
//   nbits       in   bits per frame, captured on an accepted start (0 -> 1)
//   div_load    in   load div_val into the divisor (IDLE/DONE only, min 2)
//   div_val     in   cycles per bit
//   sample      out  one-cycle strobe at mid-bit
//   bit_tick    out  one-cycle strobe at the end of each bit
//   bit_idx     out  index of the current bit, starting at 0
//   busy        out  high while a frame is running
//   done        out  level, high once the frame has completed
// ---------------------------------------------------------------------------
module bit_timer #(
  parameter int DIV_W       = 16,
  parameter int CNT_W       = 4,
  parameter int DEFAULT_DIV = 5208
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             half_start,
  input  logic             abort,
  input  logic [CNT_W-1:0] nbits,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_val,
  output logic             sample,
  output logic             bit_tick,
  output logic [CNT_W-1:0] bit_idx,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [DIV_W-1:0] DIV_MIN   = DIV_W'(2);
  localparam logic [DIV_W-1:0] DIV_RESET = DIV_W'(DEFAULT_DIV);

  state_t           state,        state_nx;
  logic [DIV_W-1:0] div_r,        div_r_nx;
  logic [CNT_W-1:0] nbits_r,      nbits_r_nx;
  logic [DIV_W-1:0] div_cnt,      div_cnt_nx;
  logic [CNT_W-1:0] bit_idx_nx;
  logic             first,        first_nx;
  logic             half_start_r, half_start_r_nx;

  logic             at_end_of_bit;
  logic             last_bit;

  // Combinational decode of the registered state: strobes line up with the
  // counter value that produces them, no output pipeline stage.
  assign at_end_of_bit = (state == ST_RUN) && (div_cnt == div_r - DIV_W'(1));
  assign last_bit      = (bit_idx == nbits_r - CNT_W'(1));

  // NOTE: every signal driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_nx        = state;
    div_r_nx        = div_r;
    nbits_r_nx      = nbits_r;
    div_cnt_nx      = div_cnt;
    bit_idx_nx      = bit_idx;
    first_nx        = first;
    half_start_r_nx = half_start_r;

    busy     = (state == ST_RUN);
    done     = (state == ST_DONE);
    bit_tick = at_end_of_bit;
    // The mid-bit point of a half-start first bit falls on the preset value
    // itself, which is not a real mid-bit, so it is suppressed.
    sample   = (state == ST_RUN) && (div_cnt == (div_r >> 1)) &&
               !(first && half_start_r);

    if (abort) begin
      state_nx   = ST_IDLE;
      div_cnt_nx = '0;
      bit_idx_nx = '0;
      first_nx   = 1'b0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            // Preset uses the current div_r even if div_load is also high.
            state_nx        = ST_RUN;
            bit_idx_nx      = '0;
            first_nx        = 1'b1;
            half_start_r_nx = half_start;
            div_cnt_nx      = half_start ? (div_r >> 1) : '0;
            nbits_r_nx      = (nbits == '0) ? CNT_W'(1) : nbits;
          end
          if (div_load) begin
            div_r_nx = (div_val < DIV_MIN) ? DIV_MIN : div_val;
          end
        end
        ST_RUN: begin
          if (at_end_of_bit) begin
            div_cnt_nx = '0;
            first_nx   = 1'b0;
            if (last_bit) begin
              state_nx = ST_DONE;
            end else begin
              bit_idx_nx = bit_idx + CNT_W'(1);
            end
          end else begin
            div_cnt_nx = div_cnt + DIV_W'(1);
          end
        end
        default: begin
          state_nx = ST_IDLE;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // NOTE: reset is synchronous; all control and datapath registers are
  // cleared because the outputs decode directly from them.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= ST_IDLE;
      div_r        <= DIV_RESET;
      nbits_r      <= CNT_W'(1);
      div_cnt      <= '0;
      bit_idx      <= '0;
      first        <= 1'b0;
      half_start_r <= 1'b0;
    end else begin
      state        <= state_nx;
      div_r        <= div_r_nx;
      nbits_r      <= nbits_r_nx;
      div_cnt      <= div_cnt_nx;
      bit_idx      <= bit_idx_nx;
      first        <= first_nx;
      half_start_r <= half_start_r_nx;
    end
  end

endmodule

// File: tb/tb_bit_timer.sv
// ---------------------------------------------------------------------------
// tb_bit_timer
//
// Directed self-checking bench for bit_timer. Cycle c of a frame is the
// clock period that begins at the edge ending cycle c-1; start is held
// during cycle 0, and outputs are sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_bit_timer;

  localparam int DIV_W = 16;
  localparam int CNT_W = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic             half_start;
  logic             abort;
  logic [CNT_W-1:0] nbits;
  logic             div_load;
  logic [DIV_W-1:0] div_val;
  logic             sample;
  logic             bit_tick;
  logic [CNT_W-1:0] bit_idx;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_fail   = 0;

  bit_timer #(
    .DIV_W      (DIV_W),
    .CNT_W      (CNT_W),
    .DEFAULT_DIV(5208)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .half_start(half_start),
    .abort     (abort),
    .nbits     (nbits),
    .div_load  (div_load),
    .div_val   (div_val),
    .sample    (sample),
    .bit_tick  (bit_tick),
    .bit_idx   (bit_idx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // {busy, done, sample, bit_tick, bit_idx}
  function automatic logic [7:0] obs();
    return {busy, done, sample, bit_tick, bit_idx};
  endfunction

  function automatic logic [7:0] pack(input bit b, input bit d, input bit s,
                                      input bit t, input int idx);
    logic [3:0] i4;
    i4 = 4'(idx);
    return {b, d, s, t, i4};
  endfunction

  // Launch a frame (start during cycle 0) and check cycles 1..ncyc against
  // the frame timing: first tick at D (or D-(D>>1) for a half start), then
  // every D cycles; samples one cycle after the mid count; done after the
  // last tick. If load_at > 0, div_load=1/div_val=9 is driven in that cycle.
  task automatic frame(input string tag, input int d, input int nb,
                       input int b, input bit half, input int ncyc,
                       input int load_at);
    int  base;
    int  last;
    int  idx;
    bit  e_tick;
    bit  e_samp;
    nbits      = CNT_W'(nb);
    half_start = half;
    start      = 1'b1;
    step();
    start      = 1'b0;
    half_start = 1'b0;
    base = half ? (d - (d >> 1)) : d;
    last = base + d * (b - 1);
    for (int c = 1; c <= ncyc; c++) begin
      e_tick = (c >= base) && (c <= last) && (((c - base) % d) == 0);
      e_samp = (c <= last) && (((c - base + d - 1) % d) == (d >> 1)) &&
               (!half || (c > base));
      if (c <= base) idx = 0;
      else           idx = (c - base - 1) / d + 1;
      if (idx > b - 1) idx = b - 1;
      check($sformatf("%s c%0d", tag, c), 32'(obs()),
            32'(pack(c <= last, c > last, e_samp, e_tick, idx)));
      div_load = 1'b0;
      if (c == load_at) begin
        div_load = 1'b1;
        div_val  = DIV_W'(9);
      end
      if (c < ncyc) step();
    end
    div_load = 1'b0;
  endtask

  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    half_start = 1'b0;
    abort      = 1'b0;
    nbits      = '0;
    div_load   = 1'b0;
    div_val    = '0;

    step();
    step();
    check("reset outputs", 32'(obs()), 32'(0));
    check("reset div_r", 32'(dut.div_r), 32'd5208);
    reset = 1'b1;
    step();
    check("idle outputs", 32'(obs()), 32'(0));

    // Load divisor 4 in IDLE.
    div_load = 1'b1;
    div_val  = DIV_W'(4);
    step();
    div_load = 1'b0;

    // Normal frame: busy 1-12, samples 3/7/11, ticks 4/8/12, done from 13.
    frame("norm", 4, 3, 3, 1'b0, 14, -1);
    // Half-start frame from DONE: ticks 2/6/10, samples 5/9, done from 11.
    frame("half", 4, 3, 3, 1'b1, 12, -1);

    // Abort at cycle 6 together with start.
    frame("abt", 4, 3, 3, 1'b0, 5, -1);
    step();
    abort = 1'b1;
    start = 1'b1;
    step();
    check("abort c7", 32'(obs()), 32'(0));
    abort = 1'b0;
    start = 1'b0;
    step();
    frame("fresh", 4, 3, 3, 1'b0, 14, -1);

    // div_load during RUN is ignored: spacing stays 4.
    frame("ldrun", 4, 3, 3, 1'b0, 14, 2);

    // div_val=1 in DONE is stored as 2.
    div_load = 1'b1;
    div_val  = DIV_W'(1);
    step();
    div_load = 1'b0;
    frame("div2", 2, 3, 3, 1'b0, 8, -1);

    // nbits=0 gives a one-bit frame.
    frame("nb0", 2, 0, 1, 1'b0, 4, -1);

    // start held high: ignored in RUN, back-to-back restart from DONE.
    frame("pre", 2, 2, 2, 1'b0, 5, -1);
    nbits = CNT_W'(2);
    start = 1'b1;
    step();
    check("hold c1", 32'(obs()), 32'(pack(1, 0, 0, 0, 0)));
    step();
    check("hold c2", 32'(obs()), 32'(pack(1, 0, 1, 1, 0)));
    step();
    check("hold c3", 32'(obs()), 32'(pack(1, 0, 0, 0, 1)));
    start = 1'b0;
    step();
    check("hold c4", 32'(obs()), 32'(pack(1, 0, 1, 1, 1)));
    step();
    check("hold c5", 32'(obs()), 32'(pack(0, 1, 0, 0, 1)));
    start = 1'b1;
    step();
    check("b2b c6", 32'(obs()), 32'(pack(1, 0, 0, 0, 0)));
    start = 1'b0;

    // Mid-frame reset at cycle 5.
    abort = 1'b1;
    step();
    abort = 1'b0;
    div_load = 1'b1;
    div_val  = DIV_W'(4);
    step();
    div_load = 1'b0;
    frame("rst", 4, 3, 3, 1'b0, 4, -1);
    step();
    reset = 1'b0;
    step();
    check("midrst outputs", 32'(obs()), 32'(0));
    check("midrst div_r", 32'(dut.div_r), 32'd5208);
    reset = 1'b1;
    step();
    check("post-rst idle", 32'(obs()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
